mmio_port_b_bridge: RTL

- Peripheral-side client of the shared dual-port BRAM's port B; the CPU keeps port A.
- Once per video frame it writes the synchronised controller buttons into a fixed memory-mapped word.
- It then bursts reads of the four Pong object words (ball X/Y, left/right paddle Y) into staging registers and commits them atomically to the display logic.
- Glue between the CPU's memory image and the VGA renderer; owns addr_b, data_b and we_b.

---
 rtl/mmio_port_b_bridge_if.sv | 11 +
 rtl/mmio_port_b_bridge.sv | 119 +++++++++++
 2 files changed

// File: rtl/mmio_port_b_bridge_if.sv
// BRAM port-B bus: address, write data and write enable from the bridge,
// read data returned by the memory one clock after the address.
interface mmio_port_b_bridge_if;
   logic [15:0] addr_b;
   logic [15:0] data_b;
   logic        we_b;
   logic [15:0] q_b;

   modport master (output addr_b, output data_b, output we_b, input q_b);
   modport slave  (input addr_b, input data_b, input we_b, output q_b);
endinterface

// File: rtl/mmio_port_b_bridge.sv
// Port-B client of the shared BRAM: once per frame, writes the synchronised buttons
// to IO_ADDR, then bursts the four Pong object words and commits them together.
module mmio_port_b_bridge #(
   parameter logic [15:0] OBJ_BASE = 16'hFF00,
   parameter logic [15:0] IO_ADDR  = 16'hFF04,
   parameter int          BTN_W    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic [BTN_W-1:0]     buttons,
   mmio_port_b_bridge_if.master bus,
   output logic [15:0]          ball_x,
   output logic [15:0]          ball_y,
   output logic [15:0]          paddle_l_y,
   output logic [15:0]          paddle_r_y,
   output logic                 obj_valid,
   output logic                 busy
);

   typedef enum logic [2:0] {IDLE, WRITE, RD0, RD1, RD2, RD3, CAP3, COMMIT} state_t;

   state_t                 state;
   logic [BTN_W-1:0]       btn_meta;
   logic [BTN_W-1:0]       btn_sync;
   logic [2:0][15:0]       staging;
   logic                   pending;
   logic [15:0]            addr_q;
   logic                   we_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         btn_meta <= buttons;
         btn_sync <= btn_meta;
      end
   end

   assign bus.addr_b = addr_q;
   assign bus.we_b   = we_q;
   // Write data follows the registered enable, so it carries btn_sync as seen in WRITE.
   assign bus.data_b = we_q ? 16'(btn_sync) : 16'h0000;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: staging is a handful of flops, not a RAM, so it is reset like the
         // rest; an aborted burst can never leak into a later commit.
         state      <= IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         staging    <= '0;
         pending    <= 1'b0;
         ball_x     <= '0;
         ball_y     <= '0;
         paddle_l_y <= '0;
         paddle_r_y <= '0;
         obj_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         obj_valid <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         if (frame_start && state != IDLE) pending <= 1'b1;

         unique case (state)
            IDLE, COMMIT: begin
               if (frame_start || pending) begin
                  state   <= WRITE;
                  pending <= 1'b0;
                  addr_q  <= IO_ADDR;
                  we_q    <= 1'b1;
                  busy    <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            WRITE: begin
               state  <= RD0;
               addr_q <= OBJ_BASE;
            end
            RD0: begin
               state  <= RD1;
               addr_q <= OBJ_BASE + 16'd1;
            end
            RD1: begin
               staging[0] <= bus.q_b;
               state      <= RD2;
               addr_q     <= OBJ_BASE + 16'd2;
            end
            RD2: begin
               staging[1] <= bus.q_b;
               state      <= RD3;
               addr_q     <= OBJ_BASE + 16'd3;
            end
            RD3: begin
               staging[2] <= bus.q_b;
               state      <= CAP3;
            end
            CAP3: begin
               // The fourth word arrives on this edge and goes straight to its output,
               // so all four coordinates change together as COMMIT begins.
               ball_x     <= staging[0];
               ball_y     <= staging[1];
               paddle_l_y <= staging[2];
               paddle_r_y <= bus.q_b;
               obj_valid  <= 1'b1;
               state      <= COMMIT;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
